gpr_wb_ctrl: RTL and testbench
==============================

// Module: gpr_wb_ctrl
// PURPOSE
// - Write side of the GPR file. Accepts results from ALU and LSU over valid/ready.
// - Arbitrates between them and drives one registered write per cycle into the GPR file.
// - Holds a busy scoreboard of destinations with a pending write.
// - Issue uses the scoreboard to stall on RAW hazards and to block WAW dispatch.
// PARAMETERS
// - XLEN   32  data width
// - NREG   32  number of architectural registers
// - AW     5   register index width; must equal $clog2(NREG)
// PORTS
// - cpu_clk     in   1     clock
// - cpu_rstn    in   1     async reset, active-low
// - disp_valid  in   1     issue dispatches an instr that writes disp_rd
// - disp_rd     in   AW    destination of dispatched instr
// - disp_ready  out  1     dispatch accepted; combinational = !busy[disp_rd]
// - alu_valid   in   1     ALU result valid
// - alu_rd      in   AW    ALU destination
// - alu_data    in   XLEN  ALU result
// - alu_ready   out  1     ALU result accepted
// - lsu_valid   in   1     load result valid
// - lsu_rd      in   AW    load destination
// - lsu_data    in   XLEN  load data
// - lsu_ready   out  1     load result accepted
// - gpr_wen     out  1     GPR write enable, active-high, registered
// - gpr_waddr   out  AW    GPR write index, registered
// - gpr_wdata   out  XLEN  GPR write data, registered
// - qry_addr0   in   AW    source 0 being read by issue
// - qry_addr1   in   AW    source 1 being read by issue
// - qry_busy0   out  1     source 0 has a pending write; issue must stall
// - qry_busy1   out  1     source 1 has a pending write; issue must stall
// BEHAVIOUR
// - Reset (async, cpu_rstn=0): busy[] = 0; gpr_wen = 0; gpr_waddr = 0; gpr_wdata = 0.
//   A reset mid-operation drops all in-flight results. No write is issued after release.
// - Arbitration is fixed priority, LSU over ALU:
//   - lsu_ready = 1 always.
//   - alu_ready = !lsu_valid.
//   - Exactly one source fires per cycle.
// - Latency: a result accepted at edge N appears on gpr_wen/waddr/wdata for cycle N..N+1,
//   one registered stage. gpr_wen drops the next cycle unless a new result fires.
// - Destination x0 (rd==0):
//   - The handshake completes normally and the result is discarded.
//   - gpr_wen stays 0 for that cycle.
//   - busy[0] is never set; disp_rd==0 is always accepted.
// - Scoreboard:
//   - Dispatch fire (disp_valid & disp_ready, rd!=0) sets busy[disp_rd] at the edge.
//   - Result fire clears busy[rd] at the same edge the registered write is launched.
//   - Simultaneous set and clear of different indices: both apply.
//   - Set and clear of the same index cannot coincide, because disp_ready is low while busy.
//   - A result for a non-busy rd (protocol error) writes the GPR and leaves busy unchanged.
//     Assertion fires in simulation.
// - Query: qry_busyN = busy[qry_addrN]; combinational; x0 always 0.
// - The GPR file bypasses same-cycle write to read.
//   An instr issuing in the cycle after the clear reads correct data.
// CONFIGURATION
// - GPR_WB_FWD_EN defined:
//   - Adds out ports qry_fwd0/1 (1 bit) and qry_fdata0/1 (XLEN).
//   - When the result firing this cycle targets qry_addrN (rd!=0): qry_fwdN = 1,
//     qry_fdataN = that result's data, and qry_busyN is forced 0.
//   - Saves one stall cycle.
// - GPR_WB_FWD_EN undefined: ports absent; qry_busyN is pure busy[] lookup.
// STRUCTURE
// - Package cpu_wb_pkg:
//   - XLEN, NREG, AW constants.
//   - typedef logic [AW-1:0] reg_idx_t.
//   - typedef enum {WB_SRC_NONE, WB_SRC_ALU, WB_SRC_LSU} wb_src_e.
//   - typedef struct {reg_idx_t rd; logic [XLEN-1:0] data;} wb_res_t.
// - Sub-module wb_scoreboard:
//   - Busy vector with set/clear ports and two query ports.
//   - Optional forward-match logic.
// - Top level holds the arbiter and the output register.
// TESTING
// - Reset release, no stimulus -> gpr_wen=0, all qry_busy=0, disp_ready=1 for every rd.
// - Dispatch rd=5; ALU result rd=5, data=0xDEADBEEF, 2 cycles later
//   -> qry_busy(5)=1 until the fire edge.
//   -> Next cycle: gpr_wen=1, waddr=5, wdata=0xDEADBEEF; busy[5]=0.
// - ALU rd=3 and LSU rd=4 valid in the same cycle -> LSU written first, alu_ready=0.
//   -> ALU rd=3 written next cycle; gpr_wen high 2 consecutive cycles.
// - Dispatch rd=7 while busy[7]=1 -> disp_ready=0.
//   -> Clear via LSU result; dispatch accepted the cycle after the clear edge.
// - ALU result rd=0, data=0x1234 -> alu_ready=1, gpr_wen stays 0, busy unchanged.
// - Reset asserted with busy[9]=1 and a result fire pending
//   -> busy cleared and gpr_wen=0 immediately.
//   -> With GPR_WB_FWD_EN: LSU rd=2 firing while qry_addr0=2 gives qry_fwd0=1,
//      qry_busy0=0, qry_fdata0=lsu_data.

Source files
------------

// File: rtl/gpr_wb_ctrl_pkg.sv
// Shared types and sizing for the GPR write-back controller.
// Keep AW consistent with NREG; every other file derives its widths from here.
package cpu_wb_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_ALU,
    WB_SRC_LSU
  } wb_src_e;

  typedef struct packed {
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_res_t;

endpackage

// File: rtl/gpr_wb_ctrl_if.sv
// Bundle of dispatch, result, GPR-write and query signals around gpr_wb_ctrl.
// Forwarding signals exist only when GPR_WB_FWD_EN is defined.
interface gpr_wb_ctrl_if;
  import cpu_wb_pkg::*;

  logic            disp_valid;
  reg_idx_t        disp_rd;
  logic            disp_ready;

  logic            alu_valid;
  reg_idx_t        alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            lsu_valid;
  reg_idx_t        lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  logic            gpr_wen;
  reg_idx_t        gpr_waddr;
  logic [XLEN-1:0] gpr_wdata;

  reg_idx_t        qry_addr0;
  reg_idx_t        qry_addr1;
  logic            qry_busy0;
  logic            qry_busy1;
`ifdef GPR_WB_FWD_EN
  logic            qry_fwd0;
  logic            qry_fwd1;
  logic [XLEN-1:0] qry_fdata0;
  logic [XLEN-1:0] qry_fdata1;
`endif

  modport master (
    output disp_valid, disp_rd, alu_valid, alu_rd, alu_data,
           lsu_valid, lsu_rd, lsu_data, qry_addr0, qry_addr1,
    input  disp_ready, alu_ready, lsu_ready, gpr_wen, gpr_waddr, gpr_wdata,
           qry_busy0, qry_busy1
`ifdef GPR_WB_FWD_EN
           , qry_fwd0, qry_fwd1, qry_fdata0, qry_fdata1
`endif
  );

  modport slave (
    input  disp_valid, disp_rd, alu_valid, alu_rd, alu_data,
           lsu_valid, lsu_rd, lsu_data, qry_addr0, qry_addr1,
    output disp_ready, alu_ready, lsu_ready, gpr_wen, gpr_waddr, gpr_wdata,
           qry_busy0, qry_busy1
`ifdef GPR_WB_FWD_EN
           , qry_fwd0, qry_fwd1, qry_fdata0, qry_fdata1
`endif
  );

endinterface

// File: rtl/gpr_wb_ctrl_scoreboard.sv
// Busy vector of destinations with a pending write, plus source-operand queries.
// GPR_WB_FWD_EN adds a same-cycle forward match that hides the busy bit being cleared.
module wb_scoreboard
  import cpu_wb_pkg::*;
(
  input  logic            cpu_clk,
  input  logic            cpu_rstn,
  input  logic            set_en,
  input  reg_idx_t        set_idx,
  input  logic            clr_en,
  input  reg_idx_t        clr_idx,
  input  reg_idx_t        chk_idx,
  output logic            chk_busy,
  input  reg_idx_t        qry_addr0,
  input  reg_idx_t        qry_addr1,
  output logic            qry_busy0,
  output logic            qry_busy1
`ifdef GPR_WB_FWD_EN
  ,
  input  logic [XLEN-1:0] clr_data,
  output logic            qry_fwd0,
  output logic            qry_fwd1,
  output logic [XLEN-1:0] qry_fdata0,
  output logic [XLEN-1:0] qry_fdata1
`endif
);

  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] busy_q;

  // Set and clear never target the same index, so their order here does not matter.
  always_comb begin
    busy_d = busy_q;
    if (set_en) busy_d[set_idx] = 1'b1;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) busy_q <= '0;
    else           busy_q <= busy_d;
  end

  assign chk_busy = busy_q[chk_idx];

`ifdef GPR_WB_FWD_EN
  logic hit0;
  logic hit1;

  assign hit0       = clr_en && (clr_idx == qry_addr0);
  assign hit1       = clr_en && (clr_idx == qry_addr1);
  assign qry_fwd0   = hit0;
  assign qry_fwd1   = hit1;
  assign qry_fdata0 = clr_data;
  assign qry_fdata1 = clr_data;
  assign qry_busy0  = busy_q[qry_addr0] && !hit0;
  assign qry_busy1  = busy_q[qry_addr1] && !hit1;
`else
  assign qry_busy0  = busy_q[qry_addr0];
  assign qry_busy1  = busy_q[qry_addr1];
`endif

  // A result for a destination that was never dispatched is a producer bug.
  result_for_idle_rd_a: assert property (
    @(posedge cpu_clk) disable iff (!cpu_rstn) clr_en |-> busy_q[clr_idx]
  );

endmodule

// File: rtl/gpr_wb_ctrl.sv
// GPR write-back controller: LSU-over-ALU arbiter, registered GPR write port, busy scoreboard.
// Optional macro GPR_WB_FWD_EN enables result forwarding on the query ports.
module gpr_wb_ctrl
  import cpu_wb_pkg::*;
(
  input  logic         cpu_clk,
  input  logic         cpu_rstn,
  gpr_wb_ctrl_if.slave bus
);

  wb_src_e         src;
  wb_res_t         res;
  logic            fire;
  logic            wr_en;
  logic            set_en;
  logic            disp_busy;

  logic            gpr_wen_d;
  logic            gpr_wen_q;
  reg_idx_t        gpr_waddr_d;
  reg_idx_t        gpr_waddr_q;
  logic [XLEN-1:0] gpr_wdata_d;
  logic [XLEN-1:0] gpr_wdata_q;

  assign bus.lsu_ready = 1'b1;
  assign bus.alu_ready = !bus.lsu_valid;

  // Loads win so a blocked ALU result simply retries next cycle.
  always_comb begin
    src = WB_SRC_NONE;
    res = '0;
    if (bus.lsu_valid) begin
      src      = WB_SRC_LSU;
      res.rd   = bus.lsu_rd;
      res.data = bus.lsu_data;
    end else if (bus.alu_valid) begin
      src      = WB_SRC_ALU;
      res.rd   = bus.alu_rd;
      res.data = bus.alu_data;
    end
  end

  assign fire   = (src != WB_SRC_NONE);
  assign wr_en  = fire && (res.rd != '0);
  assign set_en = bus.disp_valid && !disp_busy && (bus.disp_rd != '0);

  assign bus.disp_ready = !disp_busy;

  always_comb begin
    gpr_wen_d   = wr_en;
    gpr_waddr_d = gpr_waddr_q;
    gpr_wdata_d = gpr_wdata_q;
    if (wr_en) begin
      gpr_waddr_d = res.rd;
      gpr_wdata_d = res.data;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      gpr_wen_q   <= 1'b0;
      gpr_waddr_q <= '0;
      gpr_wdata_q <= '0;
    end else begin
      gpr_wen_q   <= gpr_wen_d;
      gpr_waddr_q <= gpr_waddr_d;
      gpr_wdata_q <= gpr_wdata_d;
    end
  end

  assign bus.gpr_wen   = gpr_wen_q;
  assign bus.gpr_waddr = gpr_waddr_q;
  assign bus.gpr_wdata = gpr_wdata_q;

  wb_scoreboard u_scoreboard (
    .cpu_clk    (cpu_clk),
    .cpu_rstn   (cpu_rstn),
    .set_en     (set_en),
    .set_idx    (bus.disp_rd),
    .clr_en     (wr_en),
    .clr_idx    (res.rd),
    .chk_idx    (bus.disp_rd),
    .chk_busy   (disp_busy),
    .qry_addr0  (bus.qry_addr0),
    .qry_addr1  (bus.qry_addr1),
    .qry_busy0  (bus.qry_busy0),
    .qry_busy1  (bus.qry_busy1)
`ifdef GPR_WB_FWD_EN
    ,
    .clr_data   (res.data),
    .qry_fwd0   (bus.qry_fwd0),
    .qry_fwd1   (bus.qry_fwd1),
    .qry_fdata0 (bus.qry_fdata0),
    .qry_fdata1 (bus.qry_fdata1)
`endif
  );

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Testbench for gpr_wb_ctrl: directed scenarios then random traffic against a busy-set model.
// Forwarding checks are compiled in when GPR_WB_FWD_EN is defined.
module tb_gpr_wb_ctrl;
  import cpu_wb_pkg::*;

  logic cpu_clk = 1'b0;
  logic cpu_rstn;

  always #5 cpu_clk = ~cpu_clk;

  gpr_wb_ctrl_if bus ();

  gpr_wb_ctrl dut (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .bus      (bus)
  );

  int              checks = 0;
  int              errors = 0;
  bit              busy_m [NREG];
  logic            exp_wen;
  reg_idx_t        exp_waddr;
  logic [XLEN-1:0] exp_wdata;
  int              busy_list [$];
  int              a_idx;
  int              b_idx;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    exp_wen   = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
  endtask

  task automatic set_idle();
    bus.disp_valid = 1'b0;
    bus.disp_rd    = '0;
    bus.alu_valid  = 1'b0;
    bus.alu_rd     = '0;
    bus.alu_data   = '0;
    bus.lsu_valid  = 1'b0;
    bus.lsu_rd     = '0;
    bus.lsu_data   = '0;
    bus.qry_addr0  = '0;
    bus.qry_addr1  = '0;
  endtask

  // One clock: check combinational outputs against the model, take the edge, check the write port.
  task automatic run_cycle(input string tag);
    bit              disp_ok;
    bit              disp_fire;
    bit              fired;
    bit              hit0;
    bit              hit1;
    reg_idx_t        w_rd;
    reg_idx_t        d_rd;
    logic [XLEN-1:0] w_data;
    #1;
    disp_ok   = !busy_m[bus.disp_rd];
    d_rd      = bus.disp_rd;
    disp_fire = bus.disp_valid && disp_ok && (bus.disp_rd != 0);
    fired     = bus.lsu_valid || bus.alu_valid;
    w_rd      = bus.lsu_valid ? bus.lsu_rd : bus.alu_rd;
    w_data    = bus.lsu_valid ? bus.lsu_data : bus.alu_data;
    check({tag, " disp_ready"}, bus.disp_ready, disp_ok);
    check({tag, " lsu_ready"}, bus.lsu_ready, 1);
    check({tag, " alu_ready"}, bus.alu_ready, !bus.lsu_valid);
`ifdef GPR_WB_FWD_EN
    hit0 = fired && (w_rd != 0) && (w_rd == bus.qry_addr0);
    hit1 = fired && (w_rd != 0) && (w_rd == bus.qry_addr1);
    check({tag, " qry_fwd0"}, bus.qry_fwd0, hit0);
    check({tag, " qry_fwd1"}, bus.qry_fwd1, hit1);
    if (hit0) check({tag, " qry_fdata0"}, bus.qry_fdata0, w_data);
    if (hit1) check({tag, " qry_fdata1"}, bus.qry_fdata1, w_data);
`else
    hit0 = 1'b0;
    hit1 = 1'b0;
`endif
    check({tag, " qry_busy0"}, bus.qry_busy0, busy_m[bus.qry_addr0] && !hit0);
    check({tag, " qry_busy1"}, bus.qry_busy1, busy_m[bus.qry_addr1] && !hit1);
    @(posedge cpu_clk);
    if (disp_fire) busy_m[d_rd] = 1'b1;
    exp_wen = fired && (w_rd != 0);
    if (exp_wen) begin
      busy_m[w_rd] = 1'b0;
      exp_waddr    = w_rd;
      exp_wdata    = w_data;
    end
    #1;
    check({tag, " gpr_wen"}, bus.gpr_wen, exp_wen);
    if (exp_wen) begin
      check({tag, " gpr_waddr"}, bus.gpr_waddr, exp_waddr);
      check({tag, " gpr_wdata"}, bus.gpr_wdata, exp_wdata);
    end
  endtask

  initial begin
    cpu_rstn = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(posedge cpu_clk);
    #1;
    check("reset gpr_wen", bus.gpr_wen, 0);
    check("reset gpr_waddr", bus.gpr_waddr, 0);
    check("reset gpr_wdata", bus.gpr_wdata, 0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;

    // After release with no traffic nothing is busy and every destination can dispatch.
    for (int i = 0; i < NREG; i++) begin
      bus.disp_rd   = AW'(i);
      bus.qry_addr0 = AW'(i);
      bus.qry_addr1 = AW'(NREG - 1 - i);
      #1;
      check("idle disp_ready", bus.disp_ready, 1);
      check("idle qry_busy0", bus.qry_busy0, 0);
      check("idle qry_busy1", bus.qry_busy1, 0);
      check("idle gpr_wen", bus.gpr_wen, 0);
    end
    set_idle();

    // Dispatch x5, ALU result two cycles later.
    bus.disp_valid = 1'b1; bus.disp_rd = 5'd5;
    run_cycle("t1 disp");
    set_idle(); bus.qry_addr0 = 5'd5;
    run_cycle("t1 wait");
    check("t1 busy5 held", bus.qry_busy0, 1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    run_cycle("t1 alu");
    check("t1 waddr", bus.gpr_waddr, 5);
    check("t1 wdata", bus.gpr_wdata, 32'hDEADBEEF);
    set_idle(); bus.qry_addr0 = 5'd5;
    run_cycle("t1 after");

    // Both producers valid: LSU x4 first, ALU x3 next cycle.
    bus.disp_valid = 1'b1; bus.disp_rd = 5'd3;
    run_cycle("t2 disp3");
    bus.disp_rd = 5'd4;
    run_cycle("t2 disp4");
    set_idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0000_0333;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h0000_0444;
    run_cycle("t2 both");
    check("t2 first waddr", bus.gpr_waddr, 4);
    bus.lsu_valid = 1'b0;
    run_cycle("t2 alu");
    check("t2 second waddr", bus.gpr_waddr, 3);
    check("t2 second wen", bus.gpr_wen, 1);
    set_idle();

    // WAW block on x7, released by an LSU result.
    bus.disp_valid = 1'b1; bus.disp_rd = 5'd7;
    run_cycle("t3 disp");
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h7777_0000;
    run_cycle("t3 blocked");
    bus.lsu_valid = 1'b0;
    run_cycle("t3 redisp");
    set_idle();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h7777_0001;
    run_cycle("t3 drain");
    set_idle();

    // Result to x0 is accepted and dropped.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h0000_1234;
    run_cycle("t4 x0");
    check("t4 x0 no write", bus.gpr_wen, 0);
    set_idle();

    // Random traffic: results only target destinations the model holds busy.
    for (int c = 0; c < 400; c++) begin
      busy_list = {};
      for (int r = 1; r < NREG; r++) if (busy_m[r]) busy_list.push_back(r);
      bus.disp_valid = ($urandom_range(0, 1) == 1);
      bus.disp_rd    = AW'($urandom_range(0, NREG - 1));
      bus.qry_addr0  = AW'($urandom_range(0, NREG - 1));
      bus.qry_addr1  = AW'($urandom_range(0, NREG - 1));
      bus.alu_data   = $urandom();
      bus.lsu_data   = $urandom();
      if (busy_list.size() > 0) begin
        a_idx        = $urandom_range(0, busy_list.size() - 1);
        bus.alu_rd   = AW'(busy_list[a_idx]);
        bus.qry_addr0 = ($urandom_range(0, 1) == 1) ? bus.alu_rd : bus.qry_addr0;
      end else begin
        a_idx      = 0;
        bus.alu_rd = '0;
      end
      if (busy_list.size() > 1) begin
        b_idx      = (a_idx + 1 + $urandom_range(0, busy_list.size() - 2)) % busy_list.size();
        bus.lsu_rd = AW'(busy_list[b_idx]);
        bus.qry_addr1 = ($urandom_range(0, 1) == 1) ? bus.lsu_rd : bus.qry_addr1;
      end else begin
        bus.lsu_rd = '0;
      end
      if ($urandom_range(0, 7) == 0) bus.alu_rd = '0;
      bus.alu_valid = ($urandom_range(0, 2) != 0);
      bus.lsu_valid = ($urandom_range(0, 2) == 0);
      run_cycle("rand");
    end
    set_idle();

    // Asynchronous reset with x9 busy and an LSU result about to fire.
    bus.disp_valid = 1'b1; bus.disp_rd = 5'd9;
    run_cycle("t5 disp9");
    bus.disp_rd = 5'd11;
    run_cycle("t5 disp11");
    set_idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd11; bus.alu_data = 32'hA5A5_A5A5;
    run_cycle("t5 alu");
    set_idle();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h5555_5555;
    bus.qry_addr0 = 5'd9; bus.disp_rd = 5'd9;
    #2;
    cpu_rstn = 1'b0;
    model_reset();
    #1;
    check("t5 rst gpr_wen", bus.gpr_wen, 0);
    check("t5 rst gpr_waddr", bus.gpr_waddr, 0);
    check("t5 rst gpr_wdata", bus.gpr_wdata, 0);
    check("t5 rst qry_busy0", bus.qry_busy0, 0);
    check("t5 rst disp_ready", bus.disp_ready, 1);
    @(posedge cpu_clk);
    #1;
    check("t5 held gpr_wen", bus.gpr_wen, 0);
    set_idle();
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    bus.qry_addr0 = 5'd9;
    run_cycle("t5 release");

`ifdef GPR_WB_FWD_EN
    // LSU result forwarded to a same-cycle reader of x2.
    bus.disp_valid = 1'b1; bus.disp_rd = 5'd2;
    run_cycle("t6 disp");
    set_idle();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'hC0DE_0002; bus.qry_addr0 = 5'd2;
    #1;
    check("t6 qry_fwd0", bus.qry_fwd0, 1);
    check("t6 qry_busy0", bus.qry_busy0, 0);
    check("t6 qry_fdata0", bus.qry_fdata0, 32'hC0DE_0002);
    run_cycle("t6 fwd");
    set_idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
